window_box_overlay: RTL and testbench

//  Consumer end of the extreme-point window bus. Takes the 80-bit window
//  {up,down,left,right} (each {x[9:0],y[9:0]}) from the point detector and

---
 rtl/window_box_overlay.sv | 135 +++++++++++++
 tb/tb_window_box_overlay.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_box_overlay.sv
// Draws a frame-synchronous bounding box plus extreme-point markers over an RGB stream.
// Two-stage pipeline: stage 1 registers hit tests and syncs, stage 2 selects the pixel colour.
module window_box_overlay #(
  parameter int unsigned THICK       = 2,
  parameter int unsigned MARK        = 3,
  parameter logic [23:0] BOX_RGB     = 24'hFF0000,
  parameter logic [23:0] MARK_RGB    = 24'h00FF00,
  parameter int unsigned LOST_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [23:0] rgb_in,
  input  logic [79:0] win_in,
  input  logic        win_update,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        box_valid
);

  localparam logic [79:0] WIN_INVALID = {10'd1023, 10'd1023, 10'd0, 10'd0,
                                         10'd1023, 10'd1023, 10'd0, 10'd0};
  localparam logic [10:0] TH   = 11'(THICK);
  localparam logic [10:0] MK   = 11'(MARK);
  localparam logic [7:0]  LOST = 8'(LOST_FRAMES);

  logic [79:0] r_shadow, r_active;
  logic        r_pending, r_box_valid;
  logic [7:0]  r_lost;
  logic        r_vs1, r_de1, r_hs1, r_ovl1, r_border1, r_mark1;
  logic [23:0] r_rgb1;
  logic [23:0] r_rgb2;
  logic        r_de2, r_hs2, r_vs2;

  logic        w_frame;
  logic [79:0] w_next_active;
  logic [7:0]  w_lost_next;
  logic        w_geom_next;
  logic [10:0] w_x, w_y, w_t, w_b, w_l, w_r;
  logic        w_border, w_mark;

  assign w_frame       = vs_in & ~r_vs1;
  assign w_next_active = win_update ? win_in : r_shadow;
  assign w_lost_next   = (r_pending | win_update) ? 8'd0 :
                         (r_lost >= LOST) ? LOST : r_lost + 8'd1;
  assign w_geom_next   = (w_next_active[69:60] <= w_next_active[49:40]) &&
                         (w_next_active[39:30] <= w_next_active[19:10]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= WIN_INVALID;
      r_active    <= WIN_INVALID;
      r_pending   <= 1'b0;
      r_lost      <= '0;
      r_box_valid <= 1'b0;
    end else begin
      if (win_update) r_shadow <= win_in;
      // A window arriving on the frame-edge cycle is consumed immediately, so it never stays pending
      if (w_frame) begin
        r_active    <= w_next_active;
        r_pending   <= 1'b0;
        r_lost      <= w_lost_next;
        r_box_valid <= w_geom_next && (w_lost_next < LOST);
      end else if (win_update) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_x = {1'b0, x_in};
  assign w_y = {1'b0, y_in};
  assign w_t = {1'b0, r_active[69:60]};
  assign w_b = {1'b0, r_active[49:40]};
  assign w_l = {1'b0, r_active[39:30]};
  assign w_r = {1'b0, r_active[19:10]};

  assign w_border = (w_x >= w_l) && (w_x <= w_r) && (w_y >= w_t) && (w_y <= w_b) &&
                    ((w_x < w_l + TH) || (w_x + TH > w_r) ||
                     (w_y < w_t + TH) || (w_y + TH > w_b));

  always_comb begin : marker_hit
    logic [9:0]         px, py;
    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    w_mark = 1'b0;
    px = '0; py = '0; dx = '0; dy = '0; adx = '0; ady = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      px  = r_active[(79 - 20*i) -: 10];
      py  = r_active[(69 - 20*i) -: 10];
      dx  = $signed({1'b0, x_in}) - $signed({1'b0, px});
      dy  = $signed({1'b0, y_in}) - $signed({1'b0, py});
      adx = dx[10] ? 11'(-dx) : 11'(dx);
      ady = dy[10] ? 11'(-dy) : 11'(dy);
      if (((adx <= MK) && (y_in == py)) || ((ady <= MK) && (x_in == px)))
        w_mark = 1'b1;
    end
    if (MARK == 0) w_mark = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1 <= 1'b0; r_de1 <= 1'b0; r_hs1 <= 1'b0;
      r_rgb1 <= '0; r_ovl1 <= 1'b0; r_border1 <= 1'b0; r_mark1 <= 1'b0;
      r_rgb2 <= '0; r_de2 <= 1'b0; r_hs2 <= 1'b0; r_vs2 <= 1'b0;
    end else begin
      r_vs1     <= vs_in;
      r_de1     <= de_in;
      r_hs1     <= hs_in;
      r_rgb1    <= rgb_in;
      r_ovl1    <= r_box_valid & de_in;
      r_border1 <= w_border;
      r_mark1   <= w_mark;
      r_de2     <= r_de1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      if (!r_de1)                 r_rgb2 <= '0;
      else if (r_ovl1 && r_mark1)   r_rgb2 <= MARK_RGB;
      else if (r_ovl1 && r_border1) r_rgb2 <= BOX_RGB;
      else                          r_rgb2 <= r_rgb1;
    end
  end

  assign rgb_out   = r_rgb2;
  assign de_out    = r_de2;
  assign hs_out    = r_hs2;
  assign vs_out    = r_vs2;
  assign box_valid = r_box_valid;

endmodule

// File: tb/tb_window_box_overlay.sv
// Bench for window_box_overlay: behavioural window/lost model feeds a scoreboard queue,
// plus directed pixel and box_valid checks per scenario.
module tb_window_box_overlay;

  localparam int          THICK       = 2;
  localparam int          MARK        = 3;
  localparam logic [23:0] BOX_RGB     = 24'hFF0000;
  localparam logic [23:0] MARK_RGB    = 24'h00FF00;
  localparam int          LOST_FRAMES = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x_in = '0, y_in = '0;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, win_update = 1'b0;
  logic [23:0] rgb_in = '0;
  logic [79:0] win_in = '0;
  logic [23:0] rgb_out;
  logic        de_out, hs_out, vs_out, box_valid;

  int checks = 0;
  int passes = 0;

  logic [26:0] sb_q[$];

  logic [79:0] m_shadow, m_active;
  bit          m_pending, m_bv, m_vsp;
  int          m_lost;

  localparam logic [79:0] INVALID = {10'd1023, 10'd1023, 10'd0, 10'd0, 10'd1023, 10'd1023, 10'd0, 10'd0};
  localparam logic [79:0] W2 = {10'd100, 10'd50, 10'd120, 10'd200, 10'd40, 10'd120, 10'd300, 10'd130};
  localparam logic [79:0] W3 = {10'd200, 10'd10, 10'd210, 10'd60, 10'd150, 10'd30, 10'd260, 10'd40};
  localparam logic [79:0] W5 = {10'd0, 10'd0, 10'd5, 10'd20, 10'd0, 10'd10, 10'd30, 10'd15};

  int pxs[30] = '{40, 41, 42, 39, 100, 97, 96, 100, 100, 300, 301, 299, 120, 120, 40,
                  37, 300, 299, 0, 1, 3, 4, 0, 1023, 1021, 0, 0, 10, 600, 639};
  int pys[30] = '{50, 51, 52, 50, 50, 50, 50, 53, 54, 130, 130, 129, 200, 197, 120,
                  120, 200, 199, 0, 0, 0, 0, 3, 0, 0, 1023, 1021, 10, 400, 479};

  window_box_overlay #(
    .THICK(THICK), .MARK(MARK), .BOX_RGB(BOX_RGB), .MARK_RGB(MARK_RGB), .LOST_FRAMES(LOST_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .de_in(de_in), .hs_in(hs_in),
    .vs_in(vs_in), .rgb_in(rgb_in), .win_in(win_in), .win_update(win_update),
    .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .box_valid(box_valid)
  );

  always #5 clk = ~clk;

  function automatic bit model_geom(input logic [79:0] w);
    int t, b, l, r;
    t = int'(w[69:60]); b = int'(w[49:40]); l = int'(w[39:30]); r = int'(w[19:10]);
    return (t <= b) && (l <= r);
  endfunction

  function automatic logic [23:0] model_rgb(input int x, input int y, input logic [23:0] rgb);
    int ptx[4], pty[4];
    int t, b, l, r;
    bit mk;
    ptx[0] = int'(m_active[79:70]); pty[0] = int'(m_active[69:60]);
    ptx[1] = int'(m_active[59:50]); pty[1] = int'(m_active[49:40]);
    ptx[2] = int'(m_active[39:30]); pty[2] = int'(m_active[29:20]);
    ptx[3] = int'(m_active[19:10]); pty[3] = int'(m_active[9:0]);
    t = pty[0]; b = pty[1]; l = ptx[2]; r = ptx[3];
    mk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int ax, ay;
      ax = (x > ptx[k]) ? x - ptx[k] : ptx[k] - x;
      ay = (y > pty[k]) ? y - pty[k] : pty[k] - y;
      if ((ax <= MARK && y == pty[k]) || (ay <= MARK && x == ptx[k])) mk = 1'b1;
    end
    if (mk && MARK != 0) return MARK_RGB;
    if (x >= l && x <= r && y >= t && y <= b &&
        (x < l + THICK || x + THICK > r || y < t + THICK || y + THICK > b)) return BOX_RGB;
    return rgb;
  endfunction

  task automatic reset_model();
    m_shadow = INVALID; m_active = INVALID;
    m_pending = 0; m_bv = 0; m_vsp = 0; m_lost = 0;
    sb_q.delete();
  endtask

  task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs,
                      input logic [23:0] rgb, input bit upd, input logic [79:0] win);
    logic [26:0] exp;
    bit edge_now;
    @(negedge clk);
    if (sb_q.size() >= 2) begin
      exp = sb_q.pop_front();
      checks++;
      if ({rgb_out, de_out, hs_out, vs_out} !== exp)
        $display("FAIL pipeline_out: got rgb=%h de/hs/vs=%b%b%b, want rgb=%h de/hs/vs=%b",
                 rgb_out, de_out, hs_out, vs_out, exp[26:3], exp[2:0]);
      else passes++;
    end
    x_in = 10'(x); y_in = 10'(y); de_in = de; hs_in = hs; vs_in = vs;
    rgb_in = rgb; win_update = upd; win_in = win;
    exp[26:3] = !de ? 24'h0 : (m_bv ? model_rgb(x, y, rgb) : rgb);
    exp[2:0]  = {de, hs, vs};
    sb_q.push_back(exp);
    edge_now = vs && !m_vsp;
    if (edge_now) begin
      m_active  = upd ? win : m_shadow;
      m_lost    = (m_pending || upd) ? 0 : ((m_lost < LOST_FRAMES) ? m_lost + 1 : LOST_FRAMES);
      m_pending = 0;
      m_bv      = model_geom(m_active) && (m_lost < LOST_FRAMES);
    end
    if (upd) begin
      m_shadow = win;
      if (!edge_now) m_pending = 1;
    end
    m_vsp = vs;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 24'h0, 0, '0);
  endtask

  task automatic probe(input int x, input int y, input logic [23:0] rgb);
    step(x, y, 1, 0, 0, rgb, 0, '0);
    idle();
    idle();
  endtask

  task automatic frame(input bit upd_mid, input logic [79:0] win, input bit upd_vs);
    idle();
    step(0, 0, 0, 0, 1, 24'h0, upd_vs, win);
    step(0, 0, 0, 0, 1, 24'h0, 0, '0);
    step(0, 0, 0, 0, 1, 24'h0, 0, '0);
    idle();
    for (int i = 0; i < 30; i++) begin
      step(pxs[i], pys[i], 1, 0, 0, 24'($urandom), upd_mid && (i == 15), win);
      if (i % 6 == 5) step(0, 0, 0, 1, 0, 24'h0, 0, '0);
    end
    for (int i = 0; i < 8; i++)
      step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1, 0, 0, 24'($urandom), 0, '0);
    idle();
  endtask

  task automatic test_reset();
    reset_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rgb_out !== 24'h0) $display("FAIL reset_rgb: got %h want 000000", rgb_out); else passes++;
    checks++; if (de_out !== 1'b0) $display("FAIL reset_de: got %b want 0", de_out); else passes++;
    checks++; if (hs_out !== 1'b0) $display("FAIL reset_hs: got %b want 0", hs_out); else passes++;
    checks++; if (vs_out !== 1'b0) $display("FAIL reset_vs: got %b want 0", vs_out); else passes++;
    checks++; if (box_valid !== 1'b0) $display("FAIL reset_box_valid: got %b want 0", box_valid); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_no_update();
    for (int f = 0; f < 2; f++) begin
      frame(0, '0, 0);
      checks++; if (box_valid !== 1'b0) $display("FAIL noupd_box_valid: got %b want 0", box_valid); else passes++;
    end
  endtask

  task automatic test_window();
    frame(1, W2, 0);
    checks++; if (box_valid !== 1'b0) $display("FAIL win_same_frame_valid: got %b want 0", box_valid); else passes++;
    probe(40, 50, 24'h135790);
    checks++; if (rgb_out !== 24'h135790) $display("FAIL win_same_frame_px: got %h want 135790", rgb_out); else passes++;
    frame(0, '0, 0);
    checks++; if (box_valid !== 1'b1) $display("FAIL win_next_valid: got %b want 1", box_valid); else passes++;
    probe(40, 50, 24'h111111);
    checks++; if (rgb_out !== BOX_RGB) $display("FAIL win_corner: got %h want %h", rgb_out, BOX_RGB); else passes++;
    probe(42, 52, 24'h222222);
    checks++; if (rgb_out !== 24'h222222) $display("FAIL win_interior: got %h want 222222", rgb_out); else passes++;
    probe(100, 50, 24'h333333);
    checks++; if (rgb_out !== MARK_RGB) $display("FAIL win_marker: got %h want %h", rgb_out, MARK_RGB); else passes++;
    probe(39, 50, 24'h444444);
    checks++; if (rgb_out !== 24'h444444) $display("FAIL win_outside: got %h want 444444", rgb_out); else passes++;
  endtask

  task automatic test_bypass();
    frame(0, W3, 1);
    checks++; if (box_valid !== 1'b1) $display("FAIL bypass_valid: got %b want 1", box_valid); else passes++;
    probe(150, 10, 24'h555555);
    checks++; if (rgb_out !== BOX_RGB) $display("FAIL bypass_corner: got %h want %h", rgb_out, BOX_RGB); else passes++;
    probe(40, 50, 24'h666666);
    checks++; if (rgb_out !== 24'h666666) $display("FAIL bypass_old_box: got %h want 666666", rgb_out); else passes++;
  endtask

  task automatic test_lost();
    frame(1, W2, 0);
    frame(0, '0, 0);
    for (int k = 1; k <= 8; k++) begin
      frame(0, '0, 0);
      checks++;
      if (box_valid !== bit'(k < LOST_FRAMES))
        $display("FAIL lost_frame_%0d: got %b want %b", k, box_valid, bit'(k < LOST_FRAMES));
      else passes++;
    end
    frame(1, W2, 0);
    checks++; if (box_valid !== 1'b0) $display("FAIL lost_pending: got %b want 0", box_valid); else passes++;
    frame(0, '0, 0);
    checks++; if (box_valid !== 1'b1) $display("FAIL lost_recover: got %b want 1", box_valid); else passes++;
  endtask

  task automatic test_clip();
    frame(0, W5, 1);
    checks++; if (box_valid !== 1'b1) $display("FAIL clip_valid: got %b want 1", box_valid); else passes++;
    probe(1023, 0, 24'h777777);
    checks++; if (rgb_out !== 24'h777777) $display("FAIL clip_x1023: got %h want 777777", rgb_out); else passes++;
    probe(1021, 0, 24'h787878);
    checks++; if (rgb_out !== 24'h787878) $display("FAIL clip_x1021: got %h want 787878", rgb_out); else passes++;
    probe(0, 1023, 24'h797979);
    checks++; if (rgb_out !== 24'h797979) $display("FAIL clip_y1023: got %h want 797979", rgb_out); else passes++;
    probe(0, 1021, 24'h7A7A7A);
    checks++; if (rgb_out !== 24'h7A7A7A) $display("FAIL clip_y1021: got %h want 7a7a7a", rgb_out); else passes++;
    probe(3, 0, 24'h888888);
    checks++; if (rgb_out !== MARK_RGB) $display("FAIL clip_mark_edge: got %h want %h", rgb_out, MARK_RGB); else passes++;
    probe(4, 0, 24'h999999);
    checks++; if (rgb_out !== BOX_RGB) $display("FAIL clip_past_mark: got %h want %h", rgb_out, BOX_RGB); else passes++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(10 + i, 10, 1, 1, 0, 24'hABCDEF, 0, '0);
    checks++; if (de_out !== 1'b1) $display("FAIL pre_reset_de: got %b want 1", de_out); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rgb_out, de_out, hs_out, vs_out} !== 27'h0)
      $display("FAIL midreset_outs: got rgb=%h de/hs/vs=%b%b%b want all 0", rgb_out, de_out, hs_out, vs_out); else passes++;
    checks++; if (box_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", box_valid); else passes++;
    reset_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(20, 20, 1, 1, 0, 24'h010203, 0, '0);
    checks++; if (de_out !== 1'b0) $display("FAIL resume_0clk_de: got %b want 0", de_out); else passes++;
    idle();
    checks++; if (de_out !== 1'b0) $display("FAIL resume_1clk_de: got %b want 0", de_out); else passes++;
    idle();
    checks++; if ({de_out, hs_out} !== 2'b11) $display("FAIL resume_2clk_dehs: got %b%b want 11", de_out, hs_out); else passes++;
    frame(1, W2, 0);
    frame(0, '0, 0);
    checks++; if (box_valid !== 1'b1) $display("FAIL post_reset_box: got %b want 1", box_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_no_update();
    test_window();
    test_bypass();
    test_lost();
    test_clip();
    test_reset_mid();
    repeat (3) idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
